reaction_timer: RTL and testbench

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer.sv | 182 ++++++++++++++++++
 tb/tb_reaction_timer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// -----------------------------------------------------------------------------
// reaction_timer
//   Reaction-time game controller. A Start press arms a trial: the LCD is asked
//   to refresh, then after a (1000 + RandomValue) ms delay all eight LEDs light
//   and the time until the next Start press is measured in whole milliseconds.
//   A press before the LEDs light is flagged as a cheat; no press within 500 ms
//   is flagged as slow.
//
//   Optional feature: define REACTION_TIMER_CHEAT_DETECT_EN to enable early-press
//   detection. Without it, presses while waiting for the stimulus are ignored and
//   Cheat is tied low.
//
// Parameters
//   MS_CYCLES     clock cycles per millisecond tick (>= 1)
//
// Ports
//   Clk           sole clock, rising edge
//   Rst           synchronous active-high reset
//   Start         user button (acted on at its rising edge only)
//   RandomValue   random delay offset in ms, sampled once per trial
//   LCDAck        LCD controller acknowledge, honoured only while requesting
//   LED           stimulus lamps (8'hFF while reacting)
//   ReactionTime  measured time in ms (500 on timeout, 0 on cheat)
//   Cheat         early-press flag
//   Slow          timeout flag
//   Wait          trial armed, waiting for stimulus
//   LCDUpdate     LCD refresh request
// -----------------------------------------------------------------------------
module reaction_timer #(
    parameter int MS_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [12:0] RandomValue,
    input  logic        LCDAck,
    output logic [7:0]  LED,
    output logic [9:0]  ReactionTime,
    output logic        Cheat,
    output logic        Slow,
    output logic        Wait,
    output logic        LCDUpdate
);

    localparam int            PW         = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX    = PW'(MS_CYCLES - 1);
    localparam logic [13:0]   DELAY_BASE = 14'd1000;
    localparam logic [9:0]    SLOW_LIMIT = 10'd500;

    typedef enum logic [2:0] {
        IDLE,
        LCD_REQ,
        WAIT_RANDOM,
        REACT,
        DONE,
        CHEAT,
        SLOW
    } state_t;

    state_t        state_q;
    logic          start_q;      // Start sampled last cycle, for edge detection
    logic [PW-1:0] pre_q;        // cycles within the current millisecond
    logic [13:0]   delay_q;      // milliseconds left before the stimulus
    logic [9:0]    react_q;      // whole milliseconds elapsed since LEDs lit
    logic [7:0]    led_q;
    logic [9:0]    rt_q;
    logic          slow_q;
    logic          wait_q;
    logic          lcd_q;
`ifdef REACTION_TIMER_CHEAT_DETECT_EN
    logic          cheat_q;
`endif

    logic          start_edge;
    logic          tick;
    logic [9:0]    react_d;
    logic [PW-1:0] pre_d;
    logic          expire;

    assign start_edge = Start & ~start_q;
    assign tick       = (pre_q == PRE_MAX);
    assign pre_d      = tick ? '0 : pre_q + PW'(1);
    // Elapsed count including the millisecond completing this cycle, so a
    // press on the edge that closes millisecond n reports n.
    assign react_d    = react_q + {9'd0, tick};
    // The last millisecond of the delay completes on this edge.
    assign expire     = tick && (delay_q == 14'd1);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            pre_q   <= '0;
            delay_q <= '0;
            react_q <= '0;
            led_q   <= '0;
            rt_q    <= '0;
            slow_q  <= 1'b0;
            wait_q  <= 1'b0;
            lcd_q   <= 1'b0;
`ifdef REACTION_TIMER_CHEAT_DETECT_EN
            cheat_q <= 1'b0;
`endif
        end else begin
            start_q <= Start;
            case (state_q)
                IDLE, DONE, CHEAT, SLOW: begin
                    if (start_edge) begin
                        state_q <= LCD_REQ;
                        rt_q    <= '0;
                        slow_q  <= 1'b0;
`ifdef REACTION_TIMER_CHEAT_DETECT_EN
                        cheat_q <= 1'b0;
`endif
                        lcd_q   <= 1'b1;
                        wait_q  <= 1'b1;
                    end
                end
                LCD_REQ: begin
                    if (LCDAck) begin
                        state_q <= WAIT_RANDOM;
                        lcd_q   <= 1'b0;
                        // Only sample of RandomValue for this trial.
                        delay_q <= DELAY_BASE + {1'b0, RandomValue};
                        pre_q   <= '0;
                    end
                end
                WAIT_RANDOM: begin
`ifdef REACTION_TIMER_CHEAT_DETECT_EN
                    // Early press beats a coincident expiry.
                    if (start_edge) begin
                        state_q <= CHEAT;
                        cheat_q <= 1'b1;
                        rt_q    <= '0;
                        led_q   <= '0;
                        wait_q  <= 1'b0;
                    end else
`endif
                    if (expire) begin
                        state_q <= REACT;
                        led_q   <= 8'hFF;
                        wait_q  <= 1'b0;
                        react_q <= '0;
                        pre_q   <= '0;
                    end else begin
                        pre_q <= pre_d;
                        if (tick) delay_q <= delay_q - 14'd1;
                    end
                end
                REACT: begin
                    // Timeout is checked first so a press on the 500 ms edge is slow.
                    if (react_d == SLOW_LIMIT) begin
                        state_q <= SLOW;
                        slow_q  <= 1'b1;
                        rt_q    <= SLOW_LIMIT;
                        led_q   <= '0;
                    end else if (start_edge) begin
                        state_q <= DONE;
                        rt_q    <= react_d;
                        led_q   <= '0;
                    end else begin
                        react_q <= react_d;
                        pre_q   <= pre_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign LED          = led_q;
    assign ReactionTime = rt_q;
    assign Slow         = slow_q;
    assign Wait         = wait_q;
    assign LCDUpdate    = lcd_q;
`ifdef REACTION_TIMER_CHEAT_DETECT_EN
    assign Cheat        = cheat_q;
`else
    assign Cheat        = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// -----------------------------------------------------------------------------
// tb_reaction_timer
//   Directed and randomized trials of reaction_timer (MS_CYCLES = 1). Each trial
//   is predicted from the game rules: with delay D = 1000 + RandomValue and a
//   press k cycles after the stimulus wait begins, the outcome is cheat
//   (k <= D, when detection is built in), slow (no usable press before D + 500)
//   or done with time k - D.
// -----------------------------------------------------------------------------
module tb_reaction_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        lcd_ack = 1'b0;
    logic [12:0] rnd = '0;
    logic [7:0]  led;
    logic [9:0]  rt;
    logic        cheat, slow, wt, lcd_upd;

    int checks = 0;
    int errors = 0;

`ifdef REACTION_TIMER_CHEAT_DETECT_EN
    localparam bit CHEAT_EN = 1'b1;
`else
    localparam bit CHEAT_EN = 1'b0;
`endif
    localparam int NO_PRESS = 100000;

    reaction_timer #(.MS_CYCLES(1)) dut (
        .Clk         (clk),
        .Rst         (rst),
        .Start       (start),
        .RandomValue (rnd),
        .LCDAck      (lcd_ack),
        .LED         (led),
        .ReactionTime(rt),
        .Cheat       (cheat),
        .Slow        (slow),
        .Wait        (wt),
        .LCDUpdate   (lcd_upd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".led"},   32'(led),     32'd0);
        chk({tag, ".rt"},    32'(rt),      32'd0);
        chk({tag, ".cheat"}, 32'(cheat),   32'd0);
        chk({tag, ".slow"},  32'(slow),    32'd0);
        chk({tag, ".wait"},  32'(wt),      32'd0);
        chk({tag, ".lcd"},   32'(lcd_upd), 32'd0);
    endtask

    // Outcome of one trial from the game rules. Cycle numbers count from the
    // edge that entered the stimulus wait; led_on = -1 means never lit.
    function automatic void model(input int r, input int k,
                                  output int led_on, output int end_c,
                                  output bit e_cheat, output bit e_slow, output int e_rt);
        int d = 1000 + r;
        e_cheat = 1'b0;
        e_slow  = 1'b0;
        if (CHEAT_EN && k <= d) begin
            led_on = -1; end_c = k; e_cheat = 1'b1; e_rt = 0;
        end else if (k <= d || k - d >= 500) begin
            led_on = d; end_c = d + 500; e_slow = 1'b1; e_rt = 500;
        end else begin
            led_on = d; end_c = k; e_rt = k - d;
        end
    endfunction

    // Press Start from a result/idle state, hold off the LCD ack, then ack.
    task automatic begin_trial(input int r, input int ack_delay);
        int bad = 0;
        start = 1'b1; step(); start = 1'b0;
        chk("req.lcd",   32'(lcd_upd),       32'd1);
        chk("req.wait",  32'(wt),            32'd1);
        chk("req.rt",    32'(rt),            32'd0);
        chk("req.flags", 32'({cheat, slow}), 32'd0);
        for (int i = 0; i < ack_delay; i++) begin
            rnd = 13'($urandom);
            step();
            if (lcd_upd !== 1'b1 || wt !== 1'b1 || led !== 8'h00) bad++;
        end
        chk("stall", 32'(bad), 32'd0);
        lcd_ack = 1'b1; rnd = 13'(r); step(); lcd_ack = 1'b0;
        rnd = 13'($urandom);  // must not affect the sampled delay
        chk("ack.lcd",  32'(lcd_upd), 32'd0);
        chk("ack.wait", 32'(wt),      32'd1);
    endtask

    task automatic run_trial(input int r, input int k, input int ack_delay);
        int  led_on = -1;
        int  end_c  = -1;
        int  bad    = 0;
        int  e_led, e_end, e_rt;
        bit  e_cheat, e_slow;
        int  d = 1000 + r;
        begin_trial(r, ack_delay);
        for (int c = 1; c <= d + 600; c++) begin
            start = (c == k);
            step();
            if (led === 8'hFF && led_on < 0) led_on = c;
            if (led !== 8'h00 && led !== 8'hFF) bad++;
            if (cheat === 1'b1 || slow === 1'b1 || (led_on >= 0 && led === 8'h00)) begin
                end_c = c;
                break;
            end
        end
        start = 1'b0;
        model(r, k, e_led, e_end, e_cheat, e_slow, e_rt);
        chk("led_on",  32'(led_on),  32'(e_led));
        chk("end",     32'(end_c),   32'(e_end));
        chk("cheat",   32'(cheat),   32'(e_cheat));
        chk("slow",    32'(slow),    32'(e_slow));
        chk("rt",      32'(rt),      32'(e_rt));
        chk("led_off", 32'(led),     32'd0);
        chk("wait_lo", 32'(wt),      32'd0);
        chk("lcd_lo",  32'(lcd_upd), 32'd0);
        chk("led_val", 32'(bad),     32'd0);
        // Results hold while Start is idle; stray acks and random values are ignored.
        bad = 0;
        repeat ($urandom_range(2, 6)) begin
            lcd_ack = 1'($urandom);
            rnd     = 13'($urandom);
            step();
            if ({led, rt, cheat, slow, wt, lcd_upd} !== {8'h00, 10'(e_rt), e_cheat, e_slow, 2'b00}) bad++;
        end
        lcd_ack = 1'b0;
        chk("hold", 32'(bad), 32'd0);
    endtask

    initial begin
        int r, k, cat, found;

        rst = 1'b1; start = 1'b0; lcd_ack = 1'b0;
        repeat (2) step();
        chk_idle("reset");
        rst = 1'b0; step();
        chk_idle("post_reset");

        run_trial(3, NO_PRESS, 0);     // stimulus at 1003, then timeout
        run_trial(3, 1053, 0);         // 50 ms reaction
        run_trial(2, 2, 0);            // early press
        run_trial(4, 1004, 1);         // press on the expiry edge
        run_trial(0, 1500, 3);         // press on the 500 ms edge
        run_trial(7, 1008, 0);         // fastest reaction, 1 ms
        run_trial(9, 1508, 0);         // slowest valid reaction, 499 ms
        run_trial(8191, 9191 + 123, 2);// largest offset
        run_trial(5, 1200, 100);       // long LCD stall

        for (int t = 0; t < 6; t++) begin
            r   = $urandom_range(0, 63);
            cat = $urandom_range(0, 2);
            if (cat == 0)      k = $urandom_range(1, 1000 + r);
            else if (cat == 1) k = $urandom_range(1001 + r, 1499 + r);
            else               k = NO_PRESS;
            run_trial(r, k, $urandom_range(0, 4));
        end

        // A held Start counts once: it arms a trial but is not an early press.
        start = 1'b1; repeat (4) step();
        chk("held.lcd", 32'(lcd_upd), 32'd1);
        lcd_ack = 1'b1; rnd = 13'd10; step(); lcd_ack = 1'b0;
        repeat (20) step();
        chk("held.cheat", 32'(cheat), 32'd0);
        chk("held.wait",  32'(wt),    32'd1);
        start = 1'b0; step();
        start = 1'b1; step(); start = 1'b0;
        chk("held.press", 32'(cheat), 32'(CHEAT_EN));
        chk("held.waitp", 32'(wt),    32'(!CHEAT_EN));

        // Reset mid-reaction, asserted together with Start and LCDAck.
        rst = 1'b1; step(); rst = 1'b0;
        chk_idle("rst1");
        begin_trial(5, 2);
        found = 0;
        for (int c = 0; c < 1100 && found == 0; c++) begin
            step();
            if (led === 8'hFF) found = 1;
        end
        chk("mid.lit", 32'(found), 32'd1);
        repeat (10) step();
        rst = 1'b1; start = 1'b1; lcd_ack = 1'b1; step();
        chk_idle("rst_mid_react");
        rst = 1'b0; start = 1'b0; lcd_ack = 1'b0; step();
        chk_idle("idle_after_rst");

        run_trial(1, 1010, 0);         // normal trial after reset, 9 ms

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
